fft_mux_sched: RTL and testbench
================================

FFT_MUX_SCHED -- requirements
Module: fft_mux_sched

Interface
REQ-001 SHALL have parameter N_BEATS, default 4: beats (136-bit words) per FFT frame.
REQ-002 SHALL have parameter N_STAGES, default 4: butterfly passes per frame, 1..8.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: external frame beat available.
REQ-006 SHALL have port in_ready  output  1: external beat accepted this cycle when in_valid is also high.
REQ-007 SHALL have port fb_valid  input  1: recirculated butterfly result beat available.
REQ-008 SHALL have port fb_ready  output  1: recirculated beat accepted this cycle when fb_valid is also high.
REQ-009 SHALL have port dp_valid  output  1: datapath input beat valid.
REQ-010 SHALL have port dp_ready  input  1: datapath accepts the beat.
REQ-011 SHALL have port mux_flag  output  1: select to the 136-bit data mux; 1 = recirculated path, 0 = external path.
REQ-012 SHALL have port stage  output  3: current butterfly pass index.
REQ-013 SHALL have port beat  output  $clog2(N_BEATS): beat index within the current pass.
REQ-014 SHALL have port dp_last  output  1: high with dp_valid on the final beat of the final pass.
REQ-015 SHALL have port frame_done  output  1: one-cycle pulse after a frame completes.

Function
REQ-016 SHALL implement states IDLE, LOAD, RECIRC, DONE.
REQ-017 IDLE -> LOAD when in_valid=1; no transfer occurs in that cycle.
REQ-018 In LOAD: mux_flag=0, dp_valid=in_valid, in_ready=dp_ready, fb_ready=0.
REQ-019 In RECIRC: mux_flag=1, dp_valid=fb_valid, fb_ready=dp_ready, in_ready=0.
REQ-020 In IDLE and DONE: dp_valid=0, in_ready=0, fb_ready=0.
REQ-021 A beat transfers only when dp_valid and dp_ready are both high; beat SHALL increment on each transfer and wrap from N_BEATS-1 to 0.
REQ-022 On the wrap of the last beat in LOAD: if N_STAGES=1, go to DONE; otherwise go to RECIRC with stage=1.
REQ-023 On the wrap of the last beat in RECIRC: if stage=N_STAGES-1, go to DONE; otherwise increment stage.
REQ-024 DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE with stage=0.
REQ-025 mux_flag, stage, beat and state SHALL be registers; mux_flag SHALL change only on state transitions, so it is stable for the whole pass.
REQ-026 dp_last SHALL equal dp_valid when stage=N_STAGES-1 and beat=N_BEATS-1.
REQ-027 in_valid during RECIRC/DONE SHALL be ignored (stalled, not dropped); fb_valid during IDLE/LOAD SHALL be ignored.
REQ-028 dp_ready low SHALL hold beat, stage and state unchanged; dp_valid SHALL remain as driven by the source.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, mux_flag=0, stage=0, beat=0, frame_done=0; dp_valid, in_ready, fb_ready and dp_last SHALL therefore be 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done pulse; the next frame starts from IDLE.

Configuration
REQ-031 Macro FFT_MUX_SCHED_PERF_EN defined: SHALL add output frame_cnt (16 bits) that increments on each frame_done, saturates at 16'hFFFF and resets to 0.
REQ-032 Macro undefined: frame_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the data width constant 136 and the default N_BEATS/N_STAGES values.
REQ-034 The block SHALL instantiate the existing 136-bit mux as its one sub-module only in the integration wrapper, not inside fft_mux_sched; the scheduler contains no data path.

Verification
REQ-035 Default parameters, in_valid and fb_valid held high, dp_ready=1 -> 1 idle cycle, then 4 LOAD beats with mux_flag=0, then 12 RECIRC beats with mux_flag=1 and stage 1,2,3, dp_last on the 16th beat, frame_done on the following cycle.
REQ-036 dp_ready toggling 1,0,1,0 during LOAD -> beat advances only on dp_ready=1 cycles, and the total frame still has 16 transfers.
REQ-037 rst=1 asserted at stage=2, beat=1 -> next cycle all outputs are 0 with state IDLE, and no frame_done pulse.
REQ-038 N_STAGES=1, N_BEATS=2 -> 2 LOAD beats, dp_last on the 2nd, mux_flag never 1, then frame_done.
REQ-039 in_valid=1 throughout RECIRC with fb_valid=0 -> in_ready=0 and dp_valid=0, and the state stays RECIRC.
REQ-040 With FFT_MUX_SCHED_PERF_EN defined, run 3 frames -> frame_cnt=3; preload at 16'hFFFE and run 2 frames -> frame_cnt=16'hFFFF.

Source files
------------

// File: rtl/fft_mux_sched_pkg.sv
// Shared definitions for the FFT mux scheduler: state encoding, data width
// of the 136-bit beat mux and default frame geometry.
package fft_mux_sched_pkg;

  localparam int DATA_W       = 136;
  localparam int DEF_N_BEATS  = 4;
  localparam int DEF_N_STAGES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RECIRC,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/fft_mux_sched.sv
// FFT mux scheduler: sequences one external load pass followed by
// N_STAGES-1 recirculation passes of N_BEATS beats each, driving the
// select of the 136-bit data mux (which lives in the integration wrapper).
// Optional macro FFT_MUX_SCHED_PERF_EN adds a saturating 16-bit frame_cnt.
module fft_mux_sched
  import fft_mux_sched_pkg::*;
#(
  parameter int N_BEATS  = DEF_N_BEATS,
  parameter int N_STAGES = DEF_N_STAGES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       fb_valid,
  output logic                       fb_ready,
  output logic                       dp_valid,
  input  logic                       dp_ready,
  output logic                       mux_flag,
  output logic [2:0]                 stage,
  output logic [$clog2(N_BEATS)-1:0] beat,
  output logic                       dp_last,
`ifdef FFT_MUX_SCHED_PERF_EN
  output logic [15:0]                frame_cnt,
`endif
  output logic                       frame_done
);

  localparam int                BW         = $clog2(N_BEATS);
  localparam logic [BW-1:0]     BEAT_LAST  = BW'(N_BEATS - 1);
  localparam logic [2:0]        STAGE_LAST = 3'(N_STAGES - 1);

  sched_state_e  state_q, state_d;
  logic [2:0]    stage_q, stage_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          mux_q, mux_d;
  logic          xfer;

  // State, pass/beat counters and mux select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      mux_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
      mux_q   <= mux_d;
    end
  end

  // Handshake steering, next-state and counter advance on each transfer.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    beat_d   = beat_q;
    mux_d    = mux_q;
    dp_valid = 1'b0;
    in_ready = 1'b0;
    fb_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOAD;
          mux_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        dp_valid = in_valid;
        in_ready = dp_ready;
      end
      ST_RECIRC: begin
        dp_valid = fb_valid;
        fb_ready = dp_ready;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    xfer = dp_valid && dp_ready;

    // Transfers only happen in LOAD or RECIRC, so the else arm is RECIRC.
    if (xfer) begin
      if (beat_q == BEAT_LAST) begin
        beat_d = '0;
        if (state_q == ST_LOAD) begin
          if (N_STAGES == 1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RECIRC;
            stage_d = 3'd1;
            mux_d   = 1'b1;
          end
        end else if (stage_q == STAGE_LAST) begin
          state_d = ST_DONE;
          mux_d   = 1'b0;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    dp_last    = dp_valid && (stage_q == STAGE_LAST) && (beat_q == BEAT_LAST);
    frame_done = (state_q == ST_DONE);
  end

  assign mux_flag = mux_q;
  assign stage    = stage_q;
  assign beat     = beat_q;

`ifdef FFT_MUX_SCHED_PERF_EN
  // Saturating count of completed frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if ((state_q == ST_DONE) && (frame_cnt != '1)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_mux_sched.sv
// Self-checking bench for fft_mux_sched: a default-geometry instance and an
// N_STAGES=1/N_BEATS=2 instance, each with a transfer scoreboard.
module tb_fft_mux_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc++;

  // ---------------- instance A: defaults (4 beats, 4 stages)
  logic       in_valid_a = 1'b0, fb_valid_a = 1'b0, dp_ready_a = 1'b0;
  logic       in_ready_a, fb_ready_a, dp_valid_a, mux_flag_a, dp_last_a, frame_done_a;
  logic [2:0] stage_a;
  logic [1:0] beat_a;
`ifdef FFT_MUX_SCHED_PERF_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

  fft_mux_sched dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .fb_valid(fb_valid_a), .fb_ready(fb_ready_a),
    .dp_valid(dp_valid_a), .dp_ready(dp_ready_a),
    .mux_flag(mux_flag_a), .stage(stage_a), .beat(beat_a),
    .dp_last(dp_last_a),
`ifdef FFT_MUX_SCHED_PERF_EN
    .frame_cnt(frame_cnt_a),
`endif
    .frame_done(frame_done_a)
  );

  // ---------------- instance B: single stage, 2 beats
  logic       in_valid_b = 1'b0, fb_valid_b = 1'b0, dp_ready_b = 1'b0;
  logic       in_ready_b, fb_ready_b, dp_valid_b, mux_flag_b, dp_last_b, frame_done_b;
  logic [2:0] stage_b;
  logic [0:0] beat_b;

  fft_mux_sched #(.N_BEATS(2), .N_STAGES(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .fb_valid(fb_valid_b), .fb_ready(fb_ready_b),
    .dp_valid(dp_valid_b), .dp_ready(dp_ready_b),
    .mux_flag(mux_flag_b), .stage(stage_b), .beat(beat_b),
    .dp_last(dp_last_b),
`ifdef FFT_MUX_SCHED_PERF_EN
    .frame_cnt(frame_cnt_b),
`endif
    .frame_done(frame_done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected transfer record: {mux_flag, stage[2:0], beat[1:0], dp_last}
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];

  task automatic push_frame(input bit to_b, input int unsigned nb, input int unsigned ns);
    for (int unsigned s = 0; s < ns; s++) begin
      for (int unsigned b = 0; b < nb; b++) begin
        logic [6:0] e;
        e = {(s != 0), 3'(s), 2'(b), ((s == ns - 1) && (b == nb - 1))};
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
      end
    end
  endtask

  // ---------------- monitor A
  int unsigned done_a = 0, done_cyc_a = 0;
  bit          prev_last_a = 1'b0, prev_stall_a = 1'b0;
  logic [2:0]  held_stage_a;
  logic [1:0]  held_beat_a;

  always @(negedge clk) begin
    if (rst) begin
      prev_last_a  = 1'b0;
      prev_stall_a = 1'b0;
    end else begin
      if (frame_done_a) begin
        done_a++;
        done_cyc_a = cyc;
        check("a_done_after_last", prev_last_a, 1'b1);
      end
      if (prev_stall_a) begin
        check("a_stall_beat", beat_a, held_beat_a);
        check("a_stall_stage", stage_a, held_stage_a);
      end
      prev_stall_a = dp_valid_a && !dp_ready_a;
      held_beat_a  = beat_a;
      held_stage_a = stage_a;
      if (dp_valid_a && dp_ready_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_xfer", {mux_flag_a, stage_a, beat_a, dp_last_a}, 7'h7f);
        end else begin
          logic [6:0] e;
          e = q_a.pop_front();
          check("a_xfer", {mux_flag_a, stage_a, beat_a, dp_last_a}, e);
          check("a_hs", {in_ready_a, fb_ready_a}, mux_flag_a ? 2'b01 : 2'b10);
        end
      end
      prev_last_a = dp_valid_a && dp_ready_a && dp_last_a;
    end
  end

  // ---------------- monitor B
  int unsigned done_b = 0;
  bit          prev_last_b = 1'b0;
  int unsigned mux_seen_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_last_b = 1'b0;
    end else begin
      if (mux_flag_b) mux_seen_b++;
      if (frame_done_b) begin
        done_b++;
        check("b_done_after_last", prev_last_b, 1'b1);
      end
      if (dp_valid_b && dp_ready_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_xfer", {mux_flag_b, stage_b, 1'b0, beat_b, dp_last_b}, 7'h7f);
        end else begin
          logic [6:0] e;
          e = q_b.pop_front();
          check("b_xfer", {mux_flag_b, stage_b, 1'b0, beat_b, dp_last_b}, e);
        end
      end
      prev_last_b = dp_valid_b && dp_ready_b && dp_last_b;
    end
  end

  task automatic wait_done_a(input int unsigned target, input int unsigned budget);
    for (int unsigned i = 0; i < budget && done_a < target; i++) begin
      @(posedge clk); #1;
    end
    if (done_a < target) check("a_timeout", done_a, target);
  endtask

  task automatic check_a_quiet(input string tag);
    check(tag, {dp_valid_a, in_ready_a, fb_ready_a, mux_flag_a, stage_a, beat_a,
                dp_last_a, frame_done_a}, '0);
  endtask

  initial begin
    int unsigned c0, d0;

    // Reset state
    rst = 1'b1;
    in_valid_a = 1'b1; fb_valid_a = 1'b1; dp_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_a_quiet("a_reset_outputs");
    check("b_reset_outputs", {dp_valid_b, in_ready_b, fb_ready_b, mux_flag_b, stage_b,
                              beat_b, dp_last_b, frame_done_b}, '0);

    // Full-throughput frame: 1 idle cycle, 16 transfers, frame_done next
    push_frame(1'b0, 4, 4);
    c0  = cyc;
    rst = 1'b0;
    wait_done_a(1, 40);
    check("a_frame_latency", done_cyc_a - c0, 17);
    check("a_q_empty_1", q_a.size(), 0);
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a_quiet("a_idle_after_done");

    // dp_ready toggling throughout the frame
    push_frame(1'b0, 4, 4);
    in_valid_a = 1'b1;
    for (int unsigned i = 0; i < 80 && done_a < 2; i++) begin
      dp_ready_a = ~dp_ready_a;
      @(posedge clk); #1;
    end
    check("a_toggle_done", done_a, 2);
    check("a_q_empty_2", q_a.size(), 0);
    dp_ready_a = 1'b1;
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // in_valid held, fb_valid low during RECIRC: must stall
    push_frame(1'b0, 4, 4);
    in_valid_a = 1'b1; fb_valid_a = 1'b0;
    for (int unsigned i = 0; i < 20 && !mux_flag_a; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("a_recirc_stall", {in_ready_a, dp_valid_a, mux_flag_a, stage_a, beat_a},
          {1'b0, 1'b0, 1'b1, 3'd1, 2'd0});
    check("a_recirc_q", q_a.size(), 12);
    fb_valid_a = 1'b1;
    wait_done_a(3, 40);
    check("a_q_empty_3", q_a.size(), 0);
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame at stage 2, beat 1
    push_frame(1'b0, 4, 4);
    in_valid_a = 1'b1;
    for (int unsigned i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (stage_a == 3'd2 && beat_a == 2'd1) break;
    end
    check("a_rst_point", {stage_a, beat_a}, {3'd2, 2'd1});
    d0  = done_a;
    rst = 1'b1;
    in_valid_a = 1'b0;
    @(posedge clk); #1;
    check_a_quiet("a_midframe_reset");
    q_a.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("a_no_done_after_rst", done_a, d0);

    // Next frame starts cleanly from IDLE
    push_frame(1'b0, 4, 4);
    c0 = cyc;
    in_valid_a = 1'b1;
    wait_done_a(d0 + 1, 40);
    check("a_frame_after_rst_latency", done_cyc_a - c0, 17);
    check("a_q_empty_4", q_a.size(), 0);
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single-stage instance: 2 LOAD beats, never recirculates
    push_frame(1'b1, 2, 1);
    in_valid_b = 1'b1; fb_valid_b = 1'b1; dp_ready_b = 1'b1;
    for (int unsigned i = 0; i < 20 && done_b < 1; i++) begin
      @(posedge clk); #1;
    end
    check("b_done", done_b, 1);
    check("b_q_empty", q_b.size(), 0);
    in_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b_mux_never_set", mux_seen_b, 0);

`ifdef FFT_MUX_SCHED_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    check("a_cnt_reset", frame_cnt_a, 16'h0000);
    rst = 1'b0;
    d0 = done_a;
    push_frame(1'b0, 4, 4); push_frame(1'b0, 4, 4); push_frame(1'b0, 4, 4);
    in_valid_a = 1'b1;
    wait_done_a(d0 + 3, 120);
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_cnt_3", frame_cnt_a, 16'd3);
    force dut_a.frame_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut_a.frame_cnt;
    d0 = done_a;
    push_frame(1'b0, 4, 4); push_frame(1'b0, 4, 4);
    in_valid_a = 1'b1;
    wait_done_a(d0 + 2, 80);
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_cnt_sat", frame_cnt_a, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
